// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants and state type for the tone generator
package tone_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
  localparam int unsigned FREQ_W_DEFAULT = 16;
  localparam int unsigned DIV_W_DEFAULT  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    RUN    = 2'd2
  } tone_state_t;

endpackage

// File: rtl/tone_div.sv
// rtl/tone_div.sv - sequential restoring divider, one quotient bit per cycle
module tone_div #(
  parameter int unsigned DIV_W = 32,
  parameter int unsigned DVS_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [DVS_W:0]   trial;

  // Shift the next dividend bit into the partial remainder and subtract when it fits
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    trial  = {rem_q, dvd_q[DIV_W-1]};
    if (start) begin
      dvd_d  = dividend;
      dvs_d  = divisor;
      rem_d  = '0;
      quot_d = '0;
      cnt_d  = CNT_W'(DIV_W);
    end else if (cnt_q != '0) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d  = DVS_W'(trial - {1'b0, dvs_q});
        quot_d = {quot_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d  = trial[DVS_W-1:0];
        quot_d = {quot_q[DIV_W-2:0], 1'b0};
      end
      dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) done_d = 1'b1;
    end
  end

  // Divider state registers; reset abandons any divide in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quot_q;

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave tone generator; TONE_GEN_EDGE_EN adds tone_edge output
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned FREQ_W = FREQ_W_DEFAULT,
  parameter int unsigned DIV_W  = DIV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              freq_valid,
  output logic              freq_ready,
  input  logic              enable,
  output logic              tone_out,
  output logic              busy,
`ifdef TONE_GEN_EDGE_EN
  output logic              tone_edge,
`endif
  output logic [DIV_W-1:0]  half_period
);

  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);

  tone_state_t      state_q, state_d;
  logic             tone_q, tone_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             from_run_q, from_run_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             edge_q, edge_d;

  logic             accept, accept_zero, div_start, div_done, running;
  logic [DIV_W-1:0] quot, quot_clamped;

  assign accept       = freq_valid && (state_q != DIVIDE);
  assign accept_zero  = accept && (freq_in == '0);
  assign div_start    = accept && (freq_in != '0);
  assign quot_clamped = (quot == '0) ? DIV_W'(1) : quot;
  assign running      = (state_q == RUN) || ((state_q == DIVIDE) && from_run_q);

  tone_div #(
    .DIV_W (DIV_W),
    .DVS_W (FREQ_W + 1)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  ({freq_in, 1'b0}),
    .done     (div_done),
    .quotient (quot)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: stop requests win, nonzero requests divide, divide completion runs
  always_comb begin
    state_d = state_q;
    if (accept_zero)                        state_d = IDLE;
    else if (div_start)                     state_d = DIVIDE;
    else if (state_q == DIVIDE && div_done) state_d = RUN;
  end

  // Tone datapath: gating, half-period counting, pending retune and divide results
  always_comb begin
    tone_d     = tone_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    from_run_d = from_run_q;
    en_d       = enable;
    if (accept_zero) begin
      tone_d   = 1'b0;
      cnt_d    = '0;
      half_d   = '0;
      pend_v_d = 1'b0;
    end else begin
      if (div_start) from_run_d = (state_q == RUN);
      if (running) begin
        if (!enable) begin
          tone_d = 1'b0;
          cnt_d  = '0;
        end else if (!en_q) begin
          tone_d = 1'b1;
          cnt_d  = '0;
        end else if (cnt_q == half_q - 1'b1) begin
          // A retune only takes effect here so the waveform never glitches
          tone_d = ~tone_q;
          cnt_d  = '0;
          if (pend_v_q) begin
            half_d   = pend_q;
            pend_v_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (div_done && state_q == DIVIDE) begin
        if (from_run_q) begin
          pend_d   = quot_clamped;
          pend_v_d = 1'b1;
        end else begin
          half_d = quot_clamped;
          tone_d = enable;
          cnt_d  = '0;
        end
      end
    end
    busy_d = (state_d == DIVIDE);
    edge_d = tone_d && !tone_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tone_q     <= 1'b0;
      cnt_q      <= '0;
      half_q     <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      from_run_q <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      tone_q     <= tone_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      from_run_q <= from_run_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      edge_q     <= edge_d;
    end
  end

  // Output drive
  always_comb begin
    freq_ready  = (state_q != DIVIDE);
    busy        = busy_q;
    tone_out    = tone_q;
    half_period = half_q;
  end

`ifdef TONE_GEN_EDGE_EN
  assign tone_edge = edge_q;
`else
  logic unused_edge;
  assign unused_edge = edge_q;
`endif

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - directed self-checking bench for tone_gen
module tb_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] freq_in;
  logic        freq_valid;
  logic        freq_ready;
  logic        enable;
  logic        tone_out;
  logic        busy;
`ifdef TONE_GEN_EDGE_EN
  logic        tone_edge;
`endif
  logic [31:0] half_period;

  int total = 0;
  int bad   = 0;

  tone_gen #(
    .CLK_HZ (50_000_000),
    .FREQ_W (26),
    .DIV_W  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .freq_in     (freq_in),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .enable      (enable),
    .tone_out    (tone_out),
    .busy        (busy),
`ifdef TONE_GEN_EDGE_EN
    .tone_edge   (tone_edge),
`endif
    .half_period (half_period)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [25:0] f);
    freq_in    = f;
    freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
  endtask

  task automatic wait_toggle(input int limit, output int n);
    logic t0;
    bit   seen;
    t0   = tone_out;
    seen = 0;
    n    = 0;
    while (!seen && n < limit) begin
      tick();
      n++;
      if (tone_out !== t0) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; freq_valid = 1'b0; freq_in = '0;
    tick(); tick();
    reset = 1'b0;
    total++; if (tone_out !== 1'b0) begin bad++; $display("FAIL reset_tone got=%0d want=0", tone_out); end
    total++; if (freq_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0d want=1", freq_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
    total++; if (half_period !== 32'd0) begin bad++; $display("FAIL reset_half got=%0d want=0", half_period); end
`ifdef TONE_GEN_EDGE_EN
    total++; if (tone_edge !== 1'b0) begin bad++; $display("FAIL reset_edge got=%0d want=0", tone_edge); end
`endif
  endtask

  task automatic test_440();
    send(26'd440);
    total++; if (freq_ready !== 1'b0) begin bad++; $display("FAIL a440_ready_e0 got=%0d want=0", freq_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL a440_busy_e0 got=%0d want=1", busy); end
    repeat (32) tick();
    total++; if (freq_ready !== 1'b0) begin bad++; $display("FAIL a440_ready_e32 got=%0d want=0", freq_ready); end
    total++; if (half_period !== 32'd0) begin bad++; $display("FAIL a440_half_e32 got=%0d want=0", half_period); end
    tick();
    total++; if (half_period !== 32'd56818) begin bad++; $display("FAIL a440_half got=%0d want=56818", half_period); end
    total++; if (tone_out !== 1'b1) begin bad++; $display("FAIL a440_tone got=%0d want=1", tone_out); end
    total++; if (freq_ready !== 1'b1) begin bad++; $display("FAIL a440_ready_e33 got=%0d want=1", freq_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a440_busy_e33 got=%0d want=0", busy); end
  endtask

  task automatic test_max_freq();
    send(26'd0);
    send(26'd25_000_000);
    repeat (33) tick();
    total++; if (half_period !== 32'd1) begin bad++; $display("FAIL f25m_half got=%0d want=1", half_period); end
    total++; if (tone_out !== 1'b1) begin bad++; $display("FAIL f25m_tone0 got=%0d want=1", tone_out); end
    tick();
    total++; if (tone_out !== 1'b0) begin bad++; $display("FAIL f25m_tone1 got=%0d want=0", tone_out); end
    tick();
    total++; if (tone_out !== 1'b1) begin bad++; $display("FAIL f25m_tone2 got=%0d want=1", tone_out); end
    send(26'd0);
    send(26'd30_000_000);
    repeat (33) tick();
    total++; if (half_period !== 32'd1) begin bad++; $display("FAIL f30m_clamp got=%0d want=1", half_period); end
  endtask

  task automatic test_retune_and_enable();
    int n;
    int ones;
    send(26'd0);
    send(26'd1000);
    repeat (33) tick();
    total++; if (half_period !== 32'd25000) begin bad++; $display("FAIL rt_half1000 got=%0d want=25000", half_period); end
    send(26'd2000);
    wait_toggle(30000, n);
    total++; if (n !== 24999) begin bad++; $display("FAIL rt_old_interval got=%0d want=24999", n); end
    total++; if (half_period !== 32'd12500) begin bad++; $display("FAIL rt_switch_half got=%0d want=12500", half_period); end
    wait_toggle(30000, n);
    total++; if (n !== 12500) begin bad++; $display("FAIL rt_new_interval got=%0d want=12500", n); end
    repeat (100) tick();
    enable = 1'b0;
    tick();
    total++; if (tone_out !== 1'b0) begin bad++; $display("FAIL en_low_tone got=%0d want=0", tone_out); end
    ones = 0;
    repeat (100) begin tick(); if (tone_out !== 1'b0) ones++; end
    total++; if (ones !== 0) begin bad++; $display("FAIL en_low_hold got=%0d want=0", ones); end
    enable = 1'b1;
    tick();
    total++; if (tone_out !== 1'b1) begin bad++; $display("FAIL en_rise_tone got=%0d want=1", tone_out); end
    total++; if (half_period !== 32'd12500) begin bad++; $display("FAIL en_rise_half got=%0d want=12500", half_period); end
`ifdef TONE_GEN_EDGE_EN
    total++; if (tone_edge !== 1'b1) begin bad++; $display("FAIL en_edge_pulse got=%0d want=1", tone_edge); end
`endif
    tick();
`ifdef TONE_GEN_EDGE_EN
    total++; if (tone_edge !== 1'b0) begin bad++; $display("FAIL en_edge_clear got=%0d want=0", tone_edge); end
`endif
    wait_toggle(20000, n);
    total++; if (n !== 12499) begin bad++; $display("FAIL en_phase got=%0d want=12499", n); end
  endtask

  task automatic test_stop();
    send(26'd0);
    total++; if (tone_out !== 1'b0) begin bad++; $display("FAIL stop_tone got=%0d want=0", tone_out); end
    total++; if (half_period !== 32'd0) begin bad++; $display("FAIL stop_half got=%0d want=0", half_period); end
    total++; if (freq_ready !== 1'b1) begin bad++; $display("FAIL stop_ready got=%0d want=1", freq_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%0d want=0", busy); end
  endtask

  task automatic test_reset_mid_divide();
    int stray;
    send(26'd1000);
    repeat (33) tick();
    send(26'd2000);
    repeat (5) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before got=%0d want=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (tone_out !== 1'b0) begin bad++; $display("FAIL rst_tone got=%0d want=0", tone_out); end
    total++; if (half_period !== 32'd0) begin bad++; $display("FAIL rst_half got=%0d want=0", half_period); end
    total++; if (freq_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d want=1", freq_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d want=0", busy); end
    stray = 0;
    repeat (60) begin tick(); if (tone_out !== 1'b0 || half_period !== 32'd0) stray++; end
    total++; if (stray !== 0) begin bad++; $display("FAIL rst_quiet got=%0d want=0", stray); end
  endtask

  initial begin
    test_reset();
    test_440();
    test_max_freq();
    test_retune_and_enable();
    test_stop();
    test_reset_mid_divide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
# tone_gen

Square-wave tone generator: converts a requested frequency in Hz into a square wave on `tone_out` by dividing the system clock. It is the synthesis counterpart of the frequency-measurement path. It sits between the note-selection logic, which issues frequency requests over a valid/ready handshake, and the audio output pin. A sequential divider computes the half-period, and retunes are phase-continuous with no output glitches.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `FREQ_W`, default 16: width of the frequency request.
- `DIV_W`, default 32: width of the divider and half-period counter.

- `clk`  in  1: system clock (50 MHz).
- `reset`  in  1: synchronous, active-high reset.
- `freq_in`  in  FREQ_W: requested frequency in Hz; 0 means stop.
- `freq_valid`  in  1: request valid.
- `freq_ready`  out  1: block can accept a request.
- `enable`  in  1: output gate; low forces silence.
- `tone_out`  out  1: generated square wave.
- `busy`  out  1: divider running.
- `half_period`  out  DIV_W: active half-period in clk cycles; 0 when idle.

## Operation
- States are IDLE, DIVIDE and RUN.
- A request is accepted on an edge where `freq_valid && freq_ready`. `freq_ready = (state != DIVIDE)`.
- Accepting `freq_in == 0` has the following effect on the next edge:
  - state goes to IDLE;
  - `tone_out` is driven to 0;
  - `half_period` is driven to 0;
  - the counter is driven to 0.
- Accepting `freq_in != 0`:
  - the block latches `divisor = {freq_in, 1'b0}` (FREQ_W+1 bits) and enters DIVIDE;
  - `tone_div` computes `CLK_HZ / divisor` as a restoring divide, one quotient bit per cycle, DIV_W cycles, remainder discarded (truncation).
  - A quotient of 0 (when 2·freq > CLK_HZ) is clamped to 1.
- Divide completes from IDLE: load `half_period`, set `tone_out = 1` and counter to 0, then go to RUN.
- Divide completes from RUN (retune):
  - the quotient is held in `pending` with a pending flag, and state returns to RUN;
  - the old tone keeps toggling throughout DIVIDE and after;
  - `pending` is loaded into `half_period` on the next toggle edge.
- In RUN the counter increments each cycle. When `counter == half_period-1`, `tone_out` toggles and the counter clears.
- A new request accepted in RUN while a pending value is still unloaded replaces that pending value when its divide completes.
- `enable` low:
  - `tone_out` forced to 0 and counter held at 0;
  - state, `half_period` and handshake are unaffected.
- `enable` rising: `tone_out` goes to 1 on the next edge, phase restarted.

## Timing
- Reset values: state IDLE, `tone_out` 0, `freq_ready` 1, `busy` 0, `half_period` 0, counter 0, pending flag 0.
- Latency from IDLE: accept at edge E0. DIVIDE spans E1..E(DIV_W). At E(DIV_W+1), state is RUN, `tone_out` is 1 and `half_period` is valid.
- `tone_out` then toggles at E(DIV_W+1) + k·H, so the period is 2H cycles.
- `busy` equals `(state == DIVIDE)` and is registered.
- Reset mid-DIVIDE or mid-RUN aborts everything to the reset values on that edge; the divide result is discarded.
- A pending load and a counter wrap on the same edge: the toggle occurs, then the counter restarts with the new `half_period`.
- A `freq_valid` held during DIVIDE is not accepted. The request must remain stable until handshake.

## Configuration
- `TONE_GEN_EDGE_EN` defined:
  - adds output `tone_edge` (1 bit), a one-cycle pulse registered coincident with each 0→1 transition of `tone_out`, including the enable-rising edge;
  - reset value 0.
- `TONE_GEN_EDGE_EN` undefined: the port and its logic are absent.

## Structure
- Package `tone_pkg` holds:
  - the `CLK_HZ` default constant;
  - the state enum `tone_state_t` (IDLE, DIVIDE, RUN);
  - the divider width localparams.
- Sub-module `tone_div` is a sequential restoring divider with:
  - inputs start, dividend, divisor;
  - outputs done (one-cycle pulse) and quotient;
  - fixed DIV_W-cycle latency.
- `tone_gen` holds the FSM, counter, pending register and output gating.

## Test plan
- Reset, then request 440 with `enable` = 1:
  - `freq_ready` drops for 32 cycles;
  - then `half_period` = 56818 and `tone_out` = 1;
  - `tone_out` toggles every 56818 cycles, giving a period of 113636.
- Request 25_000_000 gives `half_period` = 1 and `tone_out` toggles every cycle. Request 30_000_000 is clamped to `half_period` = 1.
- Running at 1000 (H = 25000), retune to 2000:
  - no toggle interval other than 25000 or 12500 occurs;
  - the switch to 12500 happens exactly at a toggle edge.
- Running, request 0: the next edge gives `tone_out` = 0, `half_period` = 0, state IDLE.
- Running, assert `reset` during a retune DIVIDE: all outputs return to reset values and no toggle follows.
- `enable` low for 100 cycles mid-tone: `tone_out` stays 0; after `enable` rises, `tone_out` = 1 on the next edge, with H preserved. With `TONE_GEN_EDGE_EN` defined, a single `tone_edge` pulse appears.
